std_nbdcache_vd_walker: RTL and testbench
=========================================

// Module: std_nbdcache_vd_walker
// PURPOSE
//  Requester for the valid/dirty SRAM macro (1 port, 1-cycle read latency).
//  - init: sequentially invalidates every set.
//  - flush: reads each set, hands every dirty way to the writeback path, then clears the set.
//  - Shares the SRAM port with the cache controller through an external arbiter (req/gnt).
// PARAMETERS
//  NumWords   1024  sets in the valid/dirty SRAM
//  DataWidth  128   SRAM word width; way w owns bits [w*WayBits +: WayBits]
//  ByteWidth  8     SRAM byte-enable granularity
//  NumWays    8     ways per set; WayBits = DataWidth/NumWays (>=2); slice bit0 = valid, bits[WayBits-1:1] = dirty
//  AddrWidth  derived: $clog2(NumWords), 1 if NumWords==1
// PORTS
//  clk_i         in   1          clock
//  rst_ni        in   1          async reset, active low
//  init_i        in   1          start invalidate-all (sampled in IDLE only)
//  flush_i       in   1          start flush-all (sampled in IDLE only; init_i wins if both set)
//  busy_o        out  1          walker not IDLE
//  done_o        out  1          1-cycle pulse when a walk completes
//  sram_req_o    out  1          SRAM access request to arbiter
//  sram_gnt_i    in   1          arbiter grant; access happens in a cycle with req&gnt
//  sram_we_o     out  1          write enable
//  sram_addr_o   out  AddrWidth  set index
//  sram_wdata_o  out  DataWidth  write data (always all-zero)
//  sram_be_o     out  DataWidth/ByteWidth  byte enables (all ones)
//  sram_rdata_i  in   DataWidth  read data, valid 1 cycle after granted read
//  wb_valid_o    out  1          writeback request for (wb_set_o, wb_way_o)
//  wb_ready_i    in   1          writeback accepted
//  wb_set_o      out  AddrWidth  set of dirty line
//  wb_way_o      out  $clog2(NumWays)  way of dirty line
//  dirty_cnt_o   out  32         dirty lines found in last flush (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM=IDLE, set counter 0, all outputs 0 (be all ones only while req high, else 0).
//  States: IDLE, INIT_WR, RD_REQ, RD_WAIT, SCAN, CLR_WR, DONE.
//  IDLE: init_i -> INIT_WR, set=0; else flush_i -> RD_REQ, set=0.
//  INIT_WR: req=1, we=1, wdata=0; on gnt: if set==NumWords-1 -> DONE else set++.
//  RD_REQ: req=1, we=0; on gnt -> RD_WAIT. RD_WAIT: capture sram_rdata_i into vd_q -> SCAN.
//  SCAN: pending = ways with valid & |dirty; pick lowest index; wb_valid_o=1 holds set/way stable
//   until wb_ready_i; on handshake clear that way in pending; when pending==0 -> CLR_WR.
//   Clean or invalid ways never emit writeback. wb_valid_o must not drop without ready.
//  CLR_WR: write zeros to set; on gnt: last set -> DONE else set++, -> RD_REQ.
//  DONE: done_o=1 for one cycle -> IDLE. busy_o=1 in all states but IDLE.
//  Without gnt, req/we/addr/wdata held unchanged (no retraction).
//  init_i/flush_i while busy ignored (not queued). Reset mid-walk: immediate IDLE, no done_o.
//  Set counter never wraps past NumWords-1; NumWords==1 completes after one set.
//  Latency: init = NumWords granted writes; flush >= 3*NumWords + dirty-way handshakes cycles.
// CONFIGURATION
//  NBDCACHE_VD_WALKER_STATS_EN defined: dirty_cnt_o cleared at flush start,
//   +1 per wb handshake, saturates at 2^32-1, holds after DONE; init leaves it unchanged.
//  Not defined: dirty_cnt_o tied 0, no counter flops.
// STRUCTURE
//  std_nbdcache_vd_pkg: walker_state_e enum, vd_way_valid()/vd_way_dirty() slice functions
//   parameterised by WayBits.
//  Sub-module std_nbdcache_vd_way_pick: lowest-set-bit priority encoder (pending -> way, empty).
// TESTING
//  1 init, NumWords=4, gnt always 1 -> 4 writes addr 0..3, wdata 0, done_o pulse, busy_o=0 after.
//  2 flush, set 2 rdata: way1 valid+dirty, way5 valid+dirty, way3 valid clean -> wb (2,1) then (2,5);
//    way3 never reported; set 2 then cleared to 0.
//  3 flush with wb_ready_i low 10 cycles -> wb_valid_o, wb_set_o, wb_way_o stable throughout.
//  4 gnt deasserted randomly 50% -> no lost/duplicate SRAM accesses; order addr 0..N-1 preserved.
//  5 rst_ni low mid-flush at set 1 -> all outputs 0 asynchronously; no done_o; next flush restarts at set 0.
//  6 STATS_EN, 3 dirty lines over all sets -> dirty_cnt_o=3 after done; without macro -> 0.

Source files
------------

// File: rtl/std_nbdcache_vd_pkg.sv
// Shared types and valid/dirty slice helpers for the nbdcache valid/dirty walker.
package std_nbdcache_vd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_WR,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_SCAN,
        ST_CLR_WR,
        ST_DONE
    } walker_state_e;

    // Widest SRAM word the slice helpers accept; callers zero-extend into this.
    localparam int unsigned VD_MAX_W = 1024;

    function automatic logic vd_way_valid(input logic [VD_MAX_W-1:0] data,
                                          input int unsigned way,
                                          input int unsigned way_bits);
        logic [VD_MAX_W-1:0] slice;
        slice = data >> (way * way_bits);
        return slice[0];
    endfunction

    function automatic logic vd_way_dirty(input logic [VD_MAX_W-1:0] data,
                                          input int unsigned way,
                                          input int unsigned way_bits);
        logic [VD_MAX_W-1:0] slice;
        logic [VD_MAX_W-1:0] mask;
        slice = data >> (way * way_bits + 1);
        mask  = (VD_MAX_W'(1) << (way_bits - 1)) - VD_MAX_W'(1);
        return |(slice & mask);
    endfunction

endpackage

// File: rtl/std_nbdcache_vd_way_pick.sv
// Lowest-index priority encoder over the pending dirty-way mask.
module std_nbdcache_vd_way_pick
    import std_nbdcache_vd_pkg::*;
#(
    parameter  int unsigned NumWays = 8,
    localparam int unsigned WayIdxW = (NumWays > 1) ? $clog2(NumWays) : 1
) (
    input  logic [NumWays-1:0] pending,
    output logic [WayIdxW-1:0] way,
    output logic               empty
);

    always_comb begin
        way   = '0;
        empty = (pending == '0);
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NumWays - 1; i >= 0; i--) begin
            if (pending[i]) way = WayIdxW'(i);
        end
    end

endmodule

// File: rtl/std_nbdcache_vd_walker.sv
// Valid/dirty SRAM walker: invalidate-all (init) and flush-all with dirty-way writeback.
// Optional dirty-line statistics counter enabled by defining NBDCACHE_VD_WALKER_STATS_EN.
module std_nbdcache_vd_walker
    import std_nbdcache_vd_pkg::*;
#(
    parameter  int unsigned NumWords  = 1024,
    parameter  int unsigned DataWidth = 128,
    parameter  int unsigned ByteWidth = 8,
    parameter  int unsigned NumWays   = 8,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned WayIdxW   = (NumWays > 1) ? $clog2(NumWays) : 1,
    localparam int unsigned BeWidth   = DataWidth / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 init_i,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 sram_req_o,
    input  logic                 sram_gnt_i,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [AddrWidth-1:0] wb_set_o,
    output logic [WayIdxW-1:0]   wb_way_o,
    output logic [31:0]          dirty_cnt_o
);

    localparam int unsigned          WayBits = DataWidth / NumWays;
    localparam logic [AddrWidth-1:0] LastSet = AddrWidth'(NumWords - 1);

    walker_state_e        state_q;
    logic [AddrWidth-1:0] set_q;
    logic [NumWays-1:0]   pending_q;
    logic [NumWays-1:0]   pending_d;
    logic                 req_q;
    logic                 we_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WayIdxW-1:0]   pick_way;
    logic                 pick_empty;
    logic                 last_set;
    logic                 wb_fire;

    assign last_set = (set_q == LastSet);

    // A way needs writeback only if it is both valid and has any dirty bit.
    always_comb begin
        pending_d = '0;
        for (int unsigned w = 0; w < NumWays; w++) begin
            pending_d[w] = vd_way_valid(VD_MAX_W'(sram_rdata_i), w, WayBits)
                         & vd_way_dirty(VD_MAX_W'(sram_rdata_i), w, WayBits);
        end
    end

    std_nbdcache_vd_way_pick #(
        .NumWays (NumWays)
    ) u_way_pick (
        .pending (pending_q),
        .way     (pick_way),
        .empty   (pick_empty)
    );

    assign wb_valid_o = (state_q == ST_SCAN) & ~pick_empty;
    assign wb_fire    = wb_valid_o & wb_ready_i;
    assign wb_set_o   = set_q;
    assign wb_way_o   = pick_way;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            set_q     <= '0;
            pending_q <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (init_i) begin
                        state_q <= ST_INIT_WR;
                        set_q   <= '0;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (flush_i) begin
                        state_q <= ST_RD_REQ;
                        set_q   <= '0;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_INIT_WR: begin
                    if (sram_gnt_i) begin
                        if (last_set) begin
                            state_q <= ST_DONE;
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            set_q <= set_q + AddrWidth'(1);
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (sram_gnt_i) begin
                        state_q <= ST_RD_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    pending_q <= pending_d;
                    state_q   <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (pick_empty) begin
                        state_q <= ST_CLR_WR;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                    end else if (wb_ready_i) begin
                        pending_q[pick_way] <= 1'b0;
                    end
                end
                ST_CLR_WR: begin
                    if (sram_gnt_i) begin
                        we_q <= 1'b0;
                        if (last_set) begin
                            state_q <= ST_DONE;
                            req_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RD_REQ;
                            set_q   <= set_q + AddrWidth'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef NBDCACHE_VD_WALKER_STATS_EN
    logic [31:0] dirty_cnt_q;

    // Cleared when a flush is accepted; init walks leave the count alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dirty_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && !init_i && flush_i) begin
            dirty_cnt_q <= '0;
        end else if (wb_fire && (dirty_cnt_q != '1)) begin
            dirty_cnt_q <= dirty_cnt_q + 32'd1;
        end
    end

    assign dirty_cnt_o = dirty_cnt_q;
`else
    assign dirty_cnt_o = '0;
`endif

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign sram_req_o   = req_q;
    assign sram_we_o    = we_q;
    assign sram_addr_o  = set_q;
    assign sram_wdata_o = '0;
    assign sram_be_o    = {BeWidth{req_q}};

endmodule

// File: tb/tb_std_nbdcache_vd_walker.sv
// Directed bench for std_nbdcache_vd_walker with an SRAM/writeback environment and event-order model.
module tb_std_nbdcache_vd_walker;

    localparam int NW   = 4;
    localparam int DW   = 128;
    localparam int BYW  = 8;
    localparam int NWAY = 8;
    localparam int WB   = DW / NWAY;
    localparam int AW   = 2;
    localparam int WIW  = 3;
    localparam int BEW  = DW / BYW;
`ifdef NBDCACHE_VD_WALKER_STATS_EN
    localparam int EXP_CNT = 3;
`else
    localparam int EXP_CNT = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           init_i, flush_i;
    logic           busy, done;
    logic           sram_req, sram_gnt, sram_we;
    logic [AW-1:0]  sram_addr;
    logic [DW-1:0]  sram_wdata, sram_rdata;
    logic [BEW-1:0] sram_be;
    logic           wb_valid, wb_ready;
    logic [AW-1:0]  wb_set;
    logic [WIW-1:0] wb_way;
    logic [31:0]    dirty_cnt;

    always #5 clk = ~clk;

    std_nbdcache_vd_walker #(
        .NumWords (NW), .DataWidth (DW), .ByteWidth (BYW), .NumWays (NWAY)
    ) dut (
        .clk_i (clk), .rst_ni (rst_n), .init_i (init_i), .flush_i (flush_i),
        .busy_o (busy), .done_o (done),
        .sram_req_o (sram_req), .sram_gnt_i (sram_gnt), .sram_we_o (sram_we),
        .sram_addr_o (sram_addr), .sram_wdata_o (sram_wdata), .sram_be_o (sram_be),
        .sram_rdata_i (sram_rdata),
        .wb_valid_o (wb_valid), .wb_ready_i (wb_ready), .wb_set_o (wb_set),
        .wb_way_o (wb_way), .dirty_cnt_o (dirty_cnt)
    );

    int n_vec  = 0;
    int n_fail = 0;

    logic [DW-1:0] mem [NW];
    int  exp_q[$];
    int  wb_log[$];
    int  acc_log[$];
    int  done_seen   = 0;
    bit  gnt_rand    = 1'b0;
    int  ready_block = 0;
    bit  rd_pend     = 1'b0;
    logic [AW-1:0] rd_addr;

    logic          p_req, p_gnt, p_we, p_wbv, p_wbr, p_done;
    logic [AW-1:0] p_addr, p_wset;
    logic [WIW-1:0] p_wway;

    function automatic int enc(int kind, int addr, int way);
        return kind * 256 + addr * 16 + way;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    task automatic expect_event(string name, int act);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: got event %0h required none", name, act);
        end else begin
            chk(name, act, exp_q.pop_front());
        end
    endtask

    // Spec-level expectation: init writes every set in order.
    task automatic gen_init();
        for (int s = 0; s < NW; s++) exp_q.push_back(enc(0, s, 0));
    endtask

    // Spec-level expectation: per set, read, each valid+dirty way ascending, then clear.
    task automatic gen_flush();
        logic [WB-1:0] sl;
        for (int s = 0; s < NW; s++) begin
            exp_q.push_back(enc(1, s, 0));
            for (int w = 0; w < NWAY; w++) begin
                sl = mem[s][w*WB +: WB];
                if (sl[0] && (sl[WB-1:1] != '0)) exp_q.push_back(enc(2, s, w));
            end
            exp_q.push_back(enc(0, s, 0));
        end
    endtask

    task automatic preload();
        mem[0] = {NWAY{16'h0001}};
        mem[1] = {NWAY{16'h0001}};
        mem[2] = '0;
        mem[2][16 +: 16] = 16'h0003;
        mem[2][48 +: 16] = 16'h0001;
        mem[2][80 +: 16] = 16'h0005;
        mem[2][96 +: 16] = 16'h0002;
        mem[3] = '0;
        mem[3][0 +: 16]   = 16'h8001;
        mem[3][112 +: 16] = 16'h0001;
    endtask

    task automatic monitor_cycle();
        int act;
        if (sram_req && sram_gnt) begin
            act = enc(sram_we ? 0 : 1, int'(sram_addr), 0);
            acc_log.push_back(act);
            if (sram_we) begin
                chk("wdata_zero", sram_wdata, '0);
                mem[sram_addr] = sram_wdata;
            end else begin
                rd_pend = 1'b1;
                rd_addr = sram_addr;
            end
            expect_event("sram_access", act);
        end
        if (wb_valid && wb_ready) begin
            act = enc(2, int'(wb_set), int'(wb_way));
            wb_log.push_back(act);
            expect_event("writeback", act);
        end
        chk("be", sram_be, sram_req ? {BEW{1'b1}} : {BEW{1'b0}});
        if (p_req && !p_gnt) chk("req_hold", {sram_req, sram_we, sram_addr}, {1'b1, p_we, p_addr});
        if (p_wbv && !p_wbr) chk("wb_hold", {wb_valid, wb_set, wb_way}, {1'b1, p_wset, p_wway});
        if (done) begin
            done_seen++;
            chk("done_width", p_done, 1'b0);
        end
        if (wb_valid && ready_block > 0) ready_block--;
        p_req = sram_req; p_gnt = sram_gnt; p_we = sram_we; p_addr = sram_addr;
        p_wbv = wb_valid; p_wbr = wb_ready; p_wset = wb_set; p_wway = wb_way; p_done = done;
    endtask

    // Environment: sample mid-cycle, drive SRAM/arbiter/writeback inputs just after the edge.
    initial begin
        sram_gnt = 1'b0; wb_ready = 1'b0; sram_rdata = '0;
        p_req = 0; p_gnt = 0; p_we = 0; p_wbv = 0; p_wbr = 0; p_done = 0;
        p_addr = '0; p_wset = '0; p_wway = '0;
        forever begin
            @(negedge clk);
            if (rst_n) monitor_cycle();
            else begin
                rd_pend = 1'b0;
                p_req = 0; p_wbv = 0; p_done = 0;
            end
            @(posedge clk);
            #1;
            if (rd_pend) begin
                sram_rdata = mem[rd_addr];
                rd_pend = 1'b0;
            end else begin
                sram_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
            sram_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            wb_ready = (ready_block > 0) ? 1'b0 : 1'b1;
        end
    end

    task automatic pulse_init();
        @(posedge clk); #2 init_i = 1'b1;
        @(posedge clk); #2 init_i = 1'b0;
    endtask

    task automatic pulse_flush();
        @(posedge clk); #2 flush_i = 1'b1;
        @(posedge clk); #2 flush_i = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int d0;
        d0 = done_seen;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_seen > d0) break;
        end
        chk("walk_done", (done_seen > d0), 1'b1);
        repeat (3) @(posedge clk);
        #2;
        chk("busy_after", busy, 1'b0);
        chk("events_left", exp_q.size(), 0);
    endtask

    task automatic check_cleared();
        for (int s = 0; s < NW; s++) chk("set_cleared", mem[s], '0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req", sram_req, 1'b0);
        chk("rst_we", sram_we, 1'b0);
        chk("rst_addr", sram_addr, '0);
        chk("rst_be", sram_be, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_set", wb_set, '0);
        chk("rst_wb_way", wb_way, '0);
        chk("rst_dirty_cnt", dirty_cnt, '0);
    endtask

    initial begin
        int d0;
        int k;
        rst_n = 1'b0; init_i = 1'b0; flush_i = 1'b0;
        for (int s = 0; s < NW; s++) mem[s] = {4{32'hA5A5_5A5A}};
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs();
        @(posedge clk); #2 rst_n = 1'b1;

        // Init walk; a flush request mid-walk must be ignored.
        acc_log.delete();
        gen_init();
        pulse_init();
        pulse_flush();
        wait_done(100);
        check_cleared();
        chk("init_accesses", acc_log.size(), 4);
        chk("init_first", acc_log[0], enc(0, 0, 0));
        chk("init_last", acc_log[3], enc(0, 3, 0));
        chk("init_cnt", dirty_cnt, '0);

        // Flush with writeback stalled for ten cycles; init request mid-walk ignored.
        preload();
        gen_flush();
        wb_log.delete();
        ready_block = 10;
        pulse_flush();
        pulse_init();
        wait_done(300);
        check_cleared();
        chk("wb_count", wb_log.size(), 3);
        chk("wb_0", wb_log[0], enc(2, 2, 1));
        chk("wb_1", wb_log[1], enc(2, 2, 5));
        chk("wb_2", wb_log[2], enc(2, 3, 0));
        chk("flush_cnt", dirty_cnt, EXP_CNT);

        // Random grant, flush then init.
        gnt_rand = 1'b1;
        preload();
        gen_flush();
        pulse_flush();
        wait_done(800);
        check_cleared();
        chk("rand_flush_cnt", dirty_cnt, EXP_CNT);
        gen_init();
        pulse_init();
        wait_done(400);
        chk("init_keeps_cnt", dirty_cnt, EXP_CNT);
        gnt_rand = 1'b0;

        // Reset while the flush is on set 1, then restart.
        preload();
        gen_flush();
        pulse_flush();
        k = 0;
        while (k < 100) begin
            @(posedge clk); #2;
            if (sram_req && sram_addr == 2'd1) break;
            k++;
        end
        chk("reached_set1", (k < 100), 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        d0 = done_seen;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("no_done_on_reset", done_seen, d0);
        chk("idle_after_reset", busy, 1'b0);
        preload();
        gen_flush();
        acc_log.delete();
        pulse_flush();
        wait_done(300);
        chk("restart_set0", acc_log[0], enc(1, 0, 0));
        check_cleared();
        chk("restart_cnt", dirty_cnt, EXP_CNT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
